// File: rtl/clause_cell_n.sv
// clause_cell_n: one clause of NUM_LIT literal slots. Each evaluation takes a
// snapshot of the variable values and then scans them one slot per cycle. The
// result is whether the clause is satisfied, whether it is in conflict, and a
// saturating count of free literals. When exactly one literal is free and none
// is true, the cell holds a unit implication for that literal.
//
// state | meaning
// ------+------------------------------------------------------------------
// IDLE  | waiting; wr_i loads polarities, eval_i snapshots vars and starts
// SCAN  | one slot per cycle; wr_i aborts the scan and reloads polarities
// DONE  | commit results and the implication, pulse done_o, back to IDLE
module clause_cell_n #(
   parameter int NUM_LIT = 8,
   parameter int CNT_W   = 2,
   parameter int IDX_W   = $clog2(NUM_LIT)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_i,
   input  logic [2*NUM_LIT-1:0]   lit_i,
   input  logic [2*NUM_LIT-1:0]   var_value_i,
   input  logic                   eval_i,
   input  logic                   imp_drv_i,
   output logic                   busy_o,
   output logic                   done_o,
   output logic [CNT_W-1:0]       freelitcnt_o,
   output logic                   clausesat_o,
   output logic                   conflict_o,
   output logic [NUM_LIT-1:0]     imp_valid_o,
   output logic [2*NUM_LIT-1:0]   imp_value_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   // Value of the literal in the slot currently under the scan pointer.
   typedef enum logic [2:0] {
      LS_ABSENT   = 3'd0,
      LS_FREE     = 3'd1,
      LS_TRUE     = 3'd2,
      LS_FALSE    = 3'd3,
      LS_CONFLICT = 3'd4
   } lit_state_t;

   localparam logic [1:0]       POL_NEG  = 2'b01;
   localparam logic [1:0]       POL_POS  = 2'b10;
   localparam logic [1:0]       VAR_FREE = 2'b00;
   localparam logic [1:0]       VAR_F    = 2'b01;
   localparam logic [1:0]       VAR_T    = 2'b10;
   localparam logic [1:0]       VAR_CFL  = 2'b11;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_LIT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   state_t                       state_q;
   logic [NUM_LIT-1:0][1:0]      lit_q;
   logic [NUM_LIT-1:0][1:0]      var_q;
   logic [IDX_W-1:0]             idx_q;

   // Scan accumulators.
   logic [CNT_W-1:0]             cnt_q;
   logic                         sat_q;
   logic                         cfl_q;
   logic                         any_free_q;
   logic                         multi_free_q;
   logic [IDX_W-1:0]             first_free_q;

   // Registered results.
   logic                         busy_q;
   logic                         done_q;
   logic [CNT_W-1:0]             freelitcnt_q;
   logic                         clausesat_q;
   logic                         conflict_q;
   logic [NUM_LIT-1:0]           imp_valid_q;
   logic [NUM_LIT-1:0][1:0]      imp_value_q;

   logic [1:0]                   slot_pol;
   logic [1:0]                   slot_var;
   logic                         slot_present;
   lit_state_t                   slot_st;

   // Classify the literal at the scan pointer; reserved polarity 11 is absent.
   always_comb begin
      slot_pol     = lit_q[idx_q];
      slot_var     = var_q[idx_q];
      slot_present = (slot_pol == POL_POS) || (slot_pol == POL_NEG);
      slot_st      = LS_ABSENT;
      if (slot_present) begin
         case (slot_var)
            VAR_FREE: slot_st = LS_FREE;
            VAR_CFL:  slot_st = LS_CONFLICT;
            VAR_T:    slot_st = (slot_pol == POL_POS) ? LS_TRUE : LS_FALSE;
            VAR_F:    slot_st = (slot_pol == POL_NEG) ? LS_TRUE : LS_FALSE;
            default:  slot_st = LS_ABSENT;
         endcase
      end
   end

   // Sequencer: polarity store, snapshot, slot scan and result commit.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         lit_q        <= '0;
         var_q        <= '0;
         idx_q        <= '0;
         cnt_q        <= '0;
         sat_q        <= 1'b0;
         cfl_q        <= 1'b0;
         any_free_q   <= 1'b0;
         multi_free_q <= 1'b0;
         first_free_q <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         freelitcnt_q <= '0;
         clausesat_q  <= 1'b0;
         conflict_q   <= 1'b0;
         imp_valid_q  <= '0;
         imp_value_q  <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (wr_i) begin
                  // A write in the same cycle as eval_i wins; eval_i is dropped.
                  lit_q <= lit_i;
               end else if (eval_i) begin
                  var_q        <= var_value_i;
                  idx_q        <= '0;
                  cnt_q        <= '0;
                  sat_q        <= 1'b0;
                  cfl_q        <= 1'b0;
                  any_free_q   <= 1'b0;
                  multi_free_q <= 1'b0;
                  first_free_q <= '0;
                  freelitcnt_q <= '0;
                  clausesat_q  <= 1'b0;
                  conflict_q   <= 1'b0;
                  imp_valid_q  <= '0;
                  imp_value_q  <= '0;
                  busy_q       <= 1'b1;
                  state_q      <= SCAN;
               end
            end

            SCAN: begin
               if (wr_i) begin
                  // Abort: results were cleared on acceptance and stay cleared.
                  lit_q   <= lit_i;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  case (slot_st)
                     LS_FREE: begin
                        if (cnt_q != CNT_MAX) begin
                           cnt_q <= cnt_q + CNT_W'(1);
                        end
                        if (!any_free_q) begin
                           any_free_q   <= 1'b1;
                           first_free_q <= idx_q;
                        end else begin
                           // Tracked apart from cnt_q so a narrow counter that
                           // saturates at 1 cannot fake a unit clause.
                           multi_free_q <= 1'b1;
                        end
                     end
                     LS_TRUE:     sat_q <= 1'b1;
                     LS_CONFLICT: cfl_q <= 1'b1;
                     default: ;
                  endcase
                  if (idx_q == IDX_LAST) begin
                     busy_q  <= 1'b0;
                     state_q <= DONE;
                  end else begin
                     idx_q <= idx_q + IDX_W'(1);
                  end
               end
            end

            DONE: begin
               done_q       <= 1'b1;
               freelitcnt_q <= cnt_q;
               clausesat_q  <= sat_q;
               conflict_q   <= cfl_q || (!sat_q && !any_free_q);
               if (!sat_q && !cfl_q && any_free_q && !multi_free_q) begin
                  imp_valid_q[first_free_q] <= 1'b1;
                  imp_value_q[first_free_q] <=
                     (lit_q[first_free_q] == POL_POS) ? VAR_T : VAR_F;
               end
               if (wr_i) begin
                  lit_q <= lit_i;
               end
               state_q <= IDLE;
            end

            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy_o       = busy_q;
   assign done_o       = done_q;
   assign freelitcnt_o = freelitcnt_q;
   assign clausesat_o  = clausesat_q;
   assign conflict_o   = conflict_q;

   // The implication is held internally and only driven while imp_drv_i is high.
   assign imp_valid_o  = imp_valid_q & {NUM_LIT{imp_drv_i}};
   assign imp_value_o  = imp_value_q & {(2*NUM_LIT){imp_drv_i}};

endmodule

// File: tb/tb_clause_cell_n.sv
module tb_clause_cell_n;

   localparam int N = 4;
   localparam int CW = 2;

   logic           clk = 1'b0;
   logic           rst;
   logic           wr_i;
   logic [2*N-1:0] lit_i;
   logic [2*N-1:0] var_value_i;
   logic           eval_i;
   logic           imp_drv_i;
   logic           busy_o;
   logic           done_o;
   logic [CW-1:0]  freelitcnt_o;
   logic           clausesat_o;
   logic           conflict_o;
   logic [N-1:0]   imp_valid_o;
   logic [2*N-1:0] imp_value_o;

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   clause_cell_n #(.NUM_LIT(N), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .wr_i(wr_i), .lit_i(lit_i),
      .var_value_i(var_value_i), .eval_i(eval_i), .imp_drv_i(imp_drv_i),
      .busy_o(busy_o), .done_o(done_o), .freelitcnt_o(freelitcnt_o),
      .clausesat_o(clausesat_o), .conflict_o(conflict_o),
      .imp_valid_o(imp_valid_o), .imp_value_o(imp_value_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Clause evaluation straight from the literal rules.
   function automatic void clause_eval(input logic [2*N-1:0] l, input logic [2*N-1:0] v,
                                       output logic [CW-1:0] cnt, output logic sat,
                                       output logic cfl, output logic [N-1:0] iv,
                                       output logic [2*N-1:0] ival);
      int nfree;
      int first;
      bit anyc;
      logic [1:0] p;
      logic [1:0] x;
      nfree = 0; first = -1; anyc = 0; sat = 0;
      for (int s = 0; s < N; s++) begin
         p = l[2*s +: 2];
         x = v[2*s +: 2];
         if (p == 2'b01 || p == 2'b10) begin
            if (x == 2'b00) begin
               nfree++;
               if (first < 0) first = s;
            end else if (x == 2'b11) anyc = 1;
            else if ((p == 2'b10 && x == 2'b10) || (p == 2'b01 && x == 2'b01)) sat = 1;
         end
      end
      cnt  = (nfree > (1 << CW) - 1) ? CW'((1 << CW) - 1) : CW'(nfree);
      cfl  = anyc || (!sat && nfree == 0);
      iv   = '0;
      ival = '0;
      if (!sat && !anyc && nfree == 1) begin
         iv[first] = 1'b1;
         p = l[2*first +: 2];
         ival[2*first +: 2] = (p == 2'b10) ? 2'b10 : 2'b01;
      end
   endfunction

   // Timing model: edges are numbered; outputs follow from distance to acceptance.
   int              edge_n = 0;
   int              m_acc = 0;
   bit              m_active = 0;
   logic [2*N-1:0]  m_lits = '0;
   logic [2*N-1:0]  m_snap_l = '0;
   logic [2*N-1:0]  m_snap_v = '0;
   logic [CW-1:0]   m_cnt = '0;
   logic            m_sat = 0;
   logic            m_cfl = 0;
   logic [N-1:0]    m_iv = '0;
   logic [2*N-1:0]  m_ival = '0;

   always @(posedge clk) begin
      int e;
      int d;
      e = edge_n + 1;
      d = e - m_acc;
      if (rst) begin
         m_active = 0; m_lits = '0; m_cnt = '0; m_sat = 0; m_cfl = 0;
         m_iv = '0; m_ival = '0;
      end else if (!m_active || d >= N + 2) begin
         if (wr_i) m_lits = lit_i;
         else if (eval_i) begin
            m_acc = e; m_active = 1; m_snap_l = m_lits; m_snap_v = var_value_i;
            m_cnt = '0; m_sat = 0; m_cfl = 0; m_iv = '0; m_ival = '0;
         end
      end else if (d <= N) begin
         if (wr_i) begin
            m_lits = lit_i;
            m_active = 0;
         end
      end else begin
         clause_eval(m_snap_l, m_snap_v, m_cnt, m_sat, m_cfl, m_iv, m_ival);
         if (wr_i) m_lits = lit_i;
      end
      edge_n = e;
   end

   // Cycle-by-cycle comparison against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         check("busy", busy_o, m_active && (edge_n - m_acc) <= N - 1);
         check("done", done_o, m_active && (edge_n - m_acc) == N + 1);
         check("count", freelitcnt_o, m_cnt);
         check("sat", clausesat_o, m_sat);
         check("conflict", conflict_o, m_cfl);
         check("imp_valid", imp_valid_o, m_iv & {N{imp_drv_i}});
         check("imp_value", imp_value_o, m_ival & {(2*N){imp_drv_i}});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_eval(input logic [2*N-1:0] v, output int lat);
      var_value_i = v;
      eval_i = 1'b1;
      tick();
      eval_i = 1'b0;
      var_value_i = ~v;
      lat = 0;
      while (done_o !== 1'b1 && lat < 20) begin
         tick();
         lat++;
      end
      check("done_seen", done_o, 1'b1);
   endtask

   task automatic write_lits(input logic [2*N-1:0] l);
      lit_i = l;
      wr_i = 1'b1;
      tick();
      wr_i = 1'b0;
   endtask

   initial begin
      int lat;
      int pulses;
      rst = 1'b1; wr_i = 1'b0; lit_i = '0; var_value_i = '0; eval_i = 1'b0; imp_drv_i = 1'b0;
      tick();
      chk_en = 1'b1;
      tick();
      rst = 1'b0;
      repeat (3) tick();
      check("rst_busy", busy_o, 0);
      check("rst_done", done_o, 0);
      check("rst_cnt", freelitcnt_o, 0);
      check("rst_conflict", conflict_o, 0);

      run_eval(8'h00, lat);
      check("empty_conflict", conflict_o, 1);
      check("empty_cnt", freelitcnt_o, 0);

      // s0 pos, s1 neg, s2 pos, s3 absent
      write_lits(8'b00_10_01_10);
      run_eval(8'h00, lat);
      check("latency", lat, 5);
      check("three_free_cnt", freelitcnt_o, 3);
      check("three_free_sat", clausesat_o, 0);
      check("three_free_cfl", conflict_o, 0);
      check("three_free_imp", imp_valid_o, 0);

      imp_drv_i = 1'b1;
      run_eval(8'b00_00_10_01, lat);
      check("unit_cnt", freelitcnt_o, 1);
      check("unit_valid", imp_valid_o, 4'b0100);
      check("unit_value", imp_value_o[5:4], 2'b10);
      imp_drv_i = 1'b0;
      #1;
      check("unit_gated_valid", imp_valid_o, 0);
      check("unit_gated_value", imp_value_o, 0);
      imp_drv_i = 1'b1;

      run_eval(8'b00_00_00_10, lat);
      check("sat_sat", clausesat_o, 1);
      check("sat_cfl", conflict_o, 0);
      check("sat_imp", imp_valid_o, 0);

      run_eval(8'b00_01_10_01, lat);
      check("falsified_cfl", conflict_o, 1);
      check("falsified_cnt", freelitcnt_o, 0);

      run_eval(8'b00_11_10_01, lat);
      check("varconf_cfl", conflict_o, 1);

      write_lits(8'b10_10_10_10);
      run_eval(8'h00, lat);
      check("satur_cnt", freelitcnt_o, 3);
      check("satur_imp", imp_valid_o, 0);

      // Abort during the second scan cycle.
      var_value_i = 8'h00;
      eval_i = 1'b1;
      tick();
      eval_i = 1'b0;
      tick();
      lit_i = 8'b00_00_01_10;
      wr_i = 1'b1;
      tick();
      wr_i = 1'b0;
      check("abort_busy", busy_o, 0);
      check("abort_cnt", freelitcnt_o, 0);
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (done_o === 1'b1) pulses++;
      end
      check("abort_no_done", pulses, 0);

      run_eval(8'b00_00_00_01, lat);
      check("newlit_cnt", freelitcnt_o, 1);
      check("newlit_valid", imp_valid_o, 4'b0010);
      check("newlit_value", imp_value_o, 8'b00_00_01_00);

      // Reset in the middle of a scan.
      eval_i = 1'b1;
      tick();
      eval_i = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mrst_busy", busy_o, 0);
      check("mrst_done", done_o, 0);
      check("mrst_cnt", freelitcnt_o, 0);
      check("mrst_cfl", conflict_o, 0);
      check("mrst_imp", imp_valid_o, 0);
      repeat (8) tick();

      run_eval(8'h00, lat);
      check("post_rst_empty_cfl", conflict_o, 1);
      repeat (2) tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
